gray_encoder_arbiter: RTL and testbench

//  Shares one binary-to-Gray conversion stage among N_REQ requesters.

---
 rtl/gray_encoder_arbiter_if.sv | 42 ++++
 rtl/gray_encoder_arbiter.sv | 107 ++++++++++
 tb/tb_gray_encoder_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gray_encoder_arbiter_if.sv
// Bundle of requester and consumer signals around the shared Gray encoder.
// The slave modport is the arbiter side, the master modport the stimulus side.
interface gray_encoder_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_gray;
  logic [WIDTH-1:0]       out_bin;
  logic [ID_W-1:0]        out_id;
  logic [15:0]            grant_cnt;

  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_gray,
    output out_bin,
    output out_id,
    output grant_cnt
  );

  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_gray,
    input  out_bin,
    input  out_id,
    input  grant_cnt
  );
endinterface

// File: rtl/gray_encoder_arbiter.sv
// Round-robin arbiter feeding one binary-to-Gray stage with a single-entry,
// id-tagged output register drained by a valid/ready consumer.
module gray_encoder_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  gray_encoder_arbiter_if.slave bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: a word moves on a rising edge where valid and ready are both 1.
  // req_ready may look at req_valid; a source must never gate valid on ready,
  // and must hold valid/data stable until the transfer happens.
  logic [ID_W-1:0]  r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_gray;
  logic [WIDTH-1:0] r_out_bin;
  logic [ID_W-1:0]  r_out_id;
  logic [15:0]      r_grant_cnt;

  logic             w_free;
  logic             w_accept;
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_win_idx;
  logic [ID_W-1:0]  w_next_ptr;
  logic [WIDTH-1:0] w_win_data;
  logic [WIDTH-1:0] w_win_gray;

  // The slot can take a new word if empty or being drained this same edge.
  assign w_free = !r_out_valid || bus.out_ready;

  always_comb begin : arbitrate
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;
    w_grant   = '0;
    w_win_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      sum = {1'b0, r_ptr} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!found && bus.req_valid[idx]) begin
        found        = 1'b1;
        w_grant[idx] = 1'b1;
        w_win_idx    = idx;
      end
    end
    if (!w_free || !rst_n) begin
      w_grant = '0;
    end
  end

  always_comb begin : select_data
    w_win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_accept   = |w_grant;
  assign w_win_gray = w_win_data ^ (w_win_data >> 1);
  assign w_next_ptr = (w_win_idx == ID_W'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_gray  <= '0;
      r_out_bin   <= '0;
      r_out_id    <= '0;
      r_grant_cnt <= '0;
    end else if (w_accept) begin
      r_ptr       <= w_next_ptr;
      r_out_valid <= 1'b1;
      r_out_gray  <= w_win_gray;
      r_out_bin   <= w_win_data;
      r_out_id    <= w_win_idx;
      r_grant_cnt <= r_grant_cnt + 16'd1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_gray  = r_out_gray;
  assign bus.out_bin   = r_out_bin;
  assign bus.out_id    = r_out_id;
  assign bus.grant_cnt = r_grant_cnt;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));

  // A stalled result must not change under the consumer.
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (r_out_valid && !bus.out_ready) |=>
      (r_out_valid && $stable(r_out_gray) && $stable(r_out_bin) && $stable(r_out_id)));
endmodule

// File: tb/tb_gray_encoder_arbiter.sv
// Bench for gray_encoder_arbiter: table-driven cycles plus hand-written corner
// sequences, with results checked through an expected-result queue.
module tb_gray_encoder_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 4;
  localparam int W     = 2 + 2 * WIDTH;

  typedef struct {
    int              phase;
    logic [3:0]      valid;
    logic [15:0]     data;
    logic            ordy;
    logic [3:0]      exp_rdy;
    logic [3:0]      exp_gray;
  } vec_t;

  logic clk;
  logic rst_n;

  gray_encoder_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  gray_encoder_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  vec_t         vecs[$];
  int           n_cmp;
  int           n_fail;
  logic [15:0]  model_cnt;
  logic [3:0]   gray_tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_compare();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL out_unexpected: got id=%0h bin=%0h gray=%0h expected no result at %0t",
               bus.out_id, bus.out_bin, bus.out_gray, $time);
    end else begin
      e = exp_q.pop_front();
      check("out_result{id,bin,gray}", {22'd0, bus.out_id, bus.out_bin, bus.out_gray}, {22'd0, e});
    end
  endtask

  // driver: one cycle of stimulus, ready check, scoreboard pop/push
  task automatic step(input logic [3:0] v, input logic [15:0] d, input logic ordy,
                      input logic [3:0] exp_rdy, input logic [3:0] exp_gray);
    int k;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.out_ready = ordy;
    #1;
    check("req_ready", {28'd0, bus.req_ready}, {28'd0, exp_rdy});
    if (bus.out_valid && bus.out_ready) pop_compare();
    if (exp_rdy != 4'b0000) begin
      k = 0;
      for (int i = 0; i < N_REQ; i++) if (exp_rdy[i]) k = i;
      exp_q.push_back({2'(k), d[k*4 +: 4], exp_gray});
      model_cnt = model_cnt + 16'd1;
    end
  endtask

  task automatic run_phase(input int p);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == p) begin
        step(vecs[i].valid, vecs[i].data, vecs[i].ordy, vecs[i].exp_rdy, vecs[i].exp_gray);
      end
    end
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_out_gray"},  {28'd0, bus.out_gray},  32'd0);
    check({tag, "_out_bin"},   {28'd0, bus.out_bin},   32'd0);
    check({tag, "_out_id"},    {30'd0, bus.out_id},    32'd0);
    check({tag, "_grant_cnt"}, {16'd0, bus.grant_cnt}, 32'd0);
    check({tag, "_req_ready"}, {28'd0, bus.req_ready}, 32'd0);
  endtask

  initial begin
    int n_bulk;
    n_cmp     = 0;
    n_fail    = 0;
    model_cnt = 16'd0;
    gray_tbl  = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    // phase 1: single requester sweeping 0..15, full throughput
    for (int b = 0; b < 16; b++) begin
      vecs.push_back('{1, 4'b0001, 16'(b), 1'b1, 4'b0001, gray_tbl[b]});
    end
    vecs.push_back('{1, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'h0});
    // phase 2: round robin from pointer 0, data_i = i + 8
    vecs.push_back('{2, 4'b1111, 16'hBA98, 1'b1, 4'b0001, 4'hC});
    vecs.push_back('{2, 4'b1111, 16'hBA98, 1'b1, 4'b0010, 4'hD});
    vecs.push_back('{2, 4'b1111, 16'hBA98, 1'b1, 4'b0100, 4'hF});
    vecs.push_back('{2, 4'b1111, 16'hBA98, 1'b1, 4'b1000, 4'hE});
    vecs.push_back('{2, 4'b1111, 16'hBA98, 1'b1, 4'b0001, 4'hC});
    vecs.push_back('{2, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'h0});
    // phase 3: idle keeps the pointer (at 1), then 1 wins over 2
    vecs.push_back('{3, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'h0});
    vecs.push_back('{3, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'h0});
    vecs.push_back('{3, 4'b0110, 16'h0430, 1'b1, 4'b0010, 4'h2});
    vecs.push_back('{3, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'h0});

    // reset at start, with requests present
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = 16'h1234;
    bus.out_ready = 1'b1;
    #3;
    check_reset_zero("reset_init");
    @(negedge clk);
    rst_n         = 1'b1;
    bus.req_valid = 4'b0000;

    run_phase(1);
    check("grant_cnt_sweep", {16'd0, bus.grant_cnt}, {16'd0, model_cnt});

    // backpressure: pointer at 1, requesters 0 and 2 valid
    step(4'b0101, 16'h0503, 1'b1, 4'b0100, 4'h7);
    for (int c = 0; c < 3; c++) begin
      step(4'b0101, 16'h0503, 1'b0, 4'b0000, 4'h0);
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_out_gray",  {28'd0, bus.out_gray},  32'h7);
      check("stall_out_id",    {30'd0, bus.out_id},    32'd2);
    end
    step(4'b0101, 16'h0503, 1'b1, 4'b0001, 4'h2);
    step(4'b0000, 16'h0000, 1'b1, 4'b0000, 4'h0);

    // simultaneous drain and load, no bubble
    step(4'b0010, 16'h0010, 1'b1, 4'b0010, 4'h1);
    step(4'b0100, 16'h0700, 1'b1, 4'b0100, 4'h4);
    step(4'b0000, 16'h0000, 1'b1, 4'b0000, 4'h0);
    check("no_bubble_valid", {31'd0, bus.out_valid}, 32'd1);

    // reset mid-transfer while a result is stalled
    step(4'b1000, 16'h9000, 1'b0, 4'b1000, 4'hD);
    @(negedge clk);
    #2;
    check("held_before_reset", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_zero("reset_mid");
    exp_q.delete();
    model_cnt = 16'd0;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b1;

    run_phase(2);
    check("grant_cnt_rr", {16'd0, bus.grant_cnt}, 32'd5);
    run_phase(3);
    check("grant_cnt_idle", {16'd0, bus.grant_cnt}, {16'd0, model_cnt});

    // counter wrap: stream grants until the count reaches 0xFFFF
    n_bulk = int'(16'hFFFF) - int'(model_cnt);
    @(negedge clk);
    bus.req_valid = 4'b1111;
    bus.req_data  = 16'(($urandom_range(0, 65535)));
    bus.out_ready = 1'b1;
    repeat (n_bulk) @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    #1;
    model_cnt = 16'hFFFF;
    check("grant_cnt_ffff", {16'd0, bus.grant_cnt}, {16'd0, model_cnt});
    check("bulk_drained", {31'd0, bus.out_valid}, 32'd0);
    step(4'b0100, 16'h0600, 1'b1, 4'b0100, 4'h5);
    step(4'b0000, 16'h0000, 1'b1, 4'b0000, 4'h0);
    check("grant_cnt_wrap", {16'd0, bus.grant_cnt}, {16'd0, model_cnt});
    check("grant_cnt_zero", {16'd0, bus.grant_cnt}, 32'd0);

    // final report
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
